// File: rtl/exc_sequencer.sv
// Trap/eret sequencer between the multicycle controller, CP0 and the PC register.
// Each accepted request produces one CP0 strobe cycle and then a PC redirect cycle; a masked trap is retired in one DROP cycle.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_VEC = 32'h0040_0004,
  parameter bit          EPC_PLUS4   = 1'b1,
  parameter int          IE_BIT      = 0,
  parameter int          SYS_BIT     = 1,
  parameter int          BRK_BIT     = 2,
  parameter int          TEQ_BIT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iSyscall,
  input  logic        iBreak,
  input  logic        iTeq,
  input  logic        iEret,
  input  logic [31:0] iPc,
  input  logic [31:0] iStatus,
  input  logic [31:0] iEpc,
  output logic        oException,
  output logic        oEret,
  output logic [31:0] oCause,
  output logic [31:0] oPc,
  output logic        oPcWe,
  output logic [31:0] oPcNext,
  output logic        oBusy,
  output logic        oDone,
  output logic        oTaken,
  output logic        oOverrun,
  output logic [2:0]  dbg_state
);

  // Handshake: every request input is a single-cycle pulse and is accepted only
  // while oBusy=0; oDone marks the last busy cycle, so the next request may
  // arrive on the cycle after oDone.

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_TRAP_COMMIT = 3'd1,
    S_TRAP_REDIR  = 3'd2,
    S_ERET_COMMIT = 3'd3,
    S_ERET_REDIR  = 3'd4,
    S_DROP        = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [31:0] ret_q;
  logic        overrun_q;

  logic        trap_req;
  logic        any_req;
  logic        trap_en;
  logic [4:0]  code_sel;
  logic [31:0] epc_sel;
  logic        unused_status;

  assign trap_req      = iSyscall | iBreak | iTeq;
  assign any_req       = trap_req | iEret;
  assign epc_sel       = EPC_PLUS4 ? (iPc + 32'd4) : iPc;
  assign unused_status = ^iStatus;

  // Fixed priority syscall > break > teq; the losers are simply discarded.
  always_comb begin
    code_sel = 5'd0;
    trap_en  = 1'b0;
    if (iSyscall) begin
      code_sel = 5'd8;
      trap_en  = iStatus[IE_BIT] & iStatus[SYS_BIT];
    end else if (iBreak) begin
      code_sel = 5'd9;
      trap_en  = iStatus[IE_BIT] & iStatus[BRK_BIT];
    end else if (iTeq) begin
      code_sel = 5'd13;
      trap_en  = iStatus[IE_BIT] & iStatus[TEQ_BIT];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trap_req)   state_nxt = trap_en ? S_TRAP_COMMIT : S_DROP;
        else if (iEret) state_nxt = S_ERET_COMMIT;
      end
      S_TRAP_COMMIT: state_nxt = S_TRAP_REDIR;
      S_TRAP_REDIR:  state_nxt = S_IDLE;
      S_ERET_COMMIT: state_nxt = S_ERET_REDIR;
      S_ERET_REDIR:  state_nxt = S_IDLE;
      S_DROP:        state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q    <= 5'd0;
      epc_q     <= 32'd0;
      ret_q     <= 32'd0;
      overrun_q <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (trap_req) begin
          code_q <= code_sel;
          epc_q  <= epc_sel;
        end else if (iEret) begin
          ret_q <= iEpc;
        end
      end else if (any_req) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Moore outputs: everything below depends on registered state/data only.
  always_comb begin
    oException = 1'b0;
    oEret      = 1'b0;
    oCause     = 32'd0;
    oPc        = 32'd0;
    oPcWe      = 1'b0;
    oPcNext    = 32'd0;
    oDone      = 1'b0;
    oTaken     = 1'b0;
    case (state)
      S_TRAP_COMMIT: begin
        oException = 1'b1;
        oCause     = {25'd0, code_q, 2'b00};
        oPc        = epc_q;
      end
      S_TRAP_REDIR: begin
        oPcWe   = 1'b1;
        oPcNext = HANDLER_VEC;
        oDone   = 1'b1;
        oTaken  = 1'b1;
      end
      S_ERET_COMMIT: oEret = 1'b1;
      S_ERET_REDIR: begin
        oPcWe   = 1'b1;
        oPcNext = ret_q;
        oDone   = 1'b1;
        oTaken  = 1'b1;
      end
      S_DROP: oDone = 1'b1;
      default: ;
    endcase
  end

  assign oBusy     = (state != S_IDLE);
  assign oOverrun  = overrun_q;
  assign dbg_state = state;

endmodule
